// File: rtl/fb_swap_ctrl.sv
// -----------------------------------------------------------------------------
// fb_swap_ctrl
//
// Framebuffer swap controller placed between the rasterizer core and the
// memory/display side. The rasterizer requests a swap with a rising edge on
// swap_fb and supplies the finished frame address on fb_addr. The address is
// queued, and the queue head becomes the scan-out address either at once or on
// the next vsync pulse. Which one applies is chosen by wait_vsync when the
// frame is queued.
//
// A swap is acknowledged (fb_swapped back to 1) only when a free render buffer
// exists. Double, triple and quad buffering therefore come from a single
// BUFFER_COUNT parameter.
//
// Ports:
//   aclk          clock
//   rst           synchronous reset, active high
//   swap_fb       swap request; only a rising edge counts
//   fb_addr       finished frame address, valid in the request cycle
//   fb_swapped    1 = idle/acknowledged, 0 = swap in progress
//   wait_vsync    1 = apply on vsync, 0 = apply immediately (sampled at push)
//   vsync         single-cycle pulse at display frame start
//   display_addr  current scan-out address
//   pending       number of queued frames not yet displayed
//   frames_shown  number of frames moved to display (wraps)
//   vsync_idle    vsync pulses seen with an empty queue in vsync mode (wraps)
//   swap_err      sticky protocol-violation flag, cleared only by rst
// -----------------------------------------------------------------------------
module fb_swap_ctrl #(
    parameter int                    ADDR_WIDTH    = 25,
    parameter int                    BUFFER_COUNT  = 2,
    parameter logic [ADDR_WIDTH-1:0] FB_RESET_ADDR = {ADDR_WIDTH{1'b0}},
    parameter int                    CNT_WIDTH     = 16
) (
    input  logic                            aclk,
    input  logic                            rst,
    input  logic                            swap_fb,
    input  logic [ADDR_WIDTH-1:0]           fb_addr,
    output logic                            fb_swapped,
    input  logic                            wait_vsync,
    input  logic                            vsync,
    output logic [ADDR_WIDTH-1:0]           display_addr,
    output logic [$clog2(BUFFER_COUNT)-1:0] pending,
    output logic [CNT_WIDTH-1:0]            frames_shown,
    output logic [CNT_WIDTH-1:0]            vsync_idle,
    output logic                            swap_err
);

    // Queue depth is one less than the number of physical buffers. One
    // buffer is always being scanned out.
    localparam int DEPTH  = BUFFER_COUNT - 1;
    localparam int PEND_W = $clog2(BUFFER_COUNT);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS  = 1 << PTR_W;

    localparam logic [PEND_W-1:0] DEPTH_P     = PEND_W'(DEPTH);
    localparam logic [PEND_W-1:0] ACK_LIMIT_P = PEND_W'(BUFFER_COUNT - 2);
    localparam logic [PTR_W-1:0]  LAST_PTR_P  = PTR_W'(DEPTH - 1);

    // Advance a queue pointer, wrapping modulo DEPTH. A depth of 1 leaves it at 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == LAST_PTR_P) begin
            return {PTR_W{1'b0}};
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    logic [ADDR_WIDTH-1:0] addr_mem_r [SLOTS];
    logic                  mode_mem_r [SLOTS];   // 1 = entry waits for vsync
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PEND_W-1:0]     pend_r;
    logic                  swp_q_r;
    logic                  fb_swapped_r;
    logic [ADDR_WIDTH-1:0] display_r;
    logic [CNT_WIDTH-1:0]  frames_r;
    logic [CNT_WIDTH-1:0]  idle_r;
    logic                  swap_err_r;

    logic                  req_s;
    logic                  push_s;
    logic                  err_s;
    logic                  pop_s;
    logic                  ack_s;
    logic                  idle_s;
    logic [PEND_W-1:0]     pend_next_s;

    // Request decode, pop decision, occupancy update and acknowledge decision.
    always_comb begin
        req_s  = swap_fb & ~swp_q_r;
        push_s = req_s & fb_swapped_r & (pend_r != DEPTH_P);
        err_s  = req_s & ~push_s;
        pop_s  = (pend_r != {PEND_W{1'b0}}) & (~mode_mem_r[rd_ptr_r] | vsync);
        idle_s = vsync & wait_vsync & (pend_r == {PEND_W{1'b0}});

        case ({push_s, pop_s})
            2'b10:   pend_next_s = pend_r + PEND_W'(1);
            2'b01:   pend_next_s = pend_r - PEND_W'(1);
            default: pend_next_s = pend_r;
        endcase

        // Acknowledge as soon as, after this cycle's pop, a render buffer is
        // free. A push cycle always has fb_swapped_r=1, so the earliest
        // acknowledge is one cycle after the push.
        if (!fb_swapped_r && (pend_next_s <= ACK_LIMIT_P)) begin
            ack_s = 1'b1;
        end else begin
            ack_s = 1'b0;
        end
    end

    // Frame-address queue storage; each entry also records its apply mode.
    always_ff @(posedge aclk) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                addr_mem_r[i] <= {ADDR_WIDTH{1'b0}};
                mode_mem_r[i] <= 1'b0;
            end
        end else if (push_s) begin
            addr_mem_r[wr_ptr_r] <= fb_addr;
            mode_mem_r[wr_ptr_r] <= wait_vsync;
        end
    end

    // Control state: edge detect, pointers, occupancy, display address,
    // handshake, error flag and statistic counters.
    always_ff @(posedge aclk) begin
        if (rst) begin
            // The edge detector follows swap_fb even while in reset, so a
            // level that is already high at release is not seen as a rising edge.
            swp_q_r      <= swap_fb;
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            pend_r       <= {PEND_W{1'b0}};
            fb_swapped_r <= 1'b1;
            display_r    <= FB_RESET_ADDR;
            frames_r     <= {CNT_WIDTH{1'b0}};
            idle_r       <= {CNT_WIDTH{1'b0}};
            swap_err_r   <= 1'b0;
        end else begin
            swp_q_r <= swap_fb;
            pend_r  <= pend_next_s;

            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end

            if (pop_s) begin
                rd_ptr_r  <= ptr_inc(rd_ptr_r);
                display_r <= addr_mem_r[rd_ptr_r];
                frames_r  <= frames_r + CNT_WIDTH'(1);
            end

            if (push_s) begin
                fb_swapped_r <= 1'b0;
            end else if (ack_s) begin
                fb_swapped_r <= 1'b1;
            end

            if (err_s) begin
                swap_err_r <= 1'b1;
            end

            if (idle_s) begin
                idle_r <= idle_r + CNT_WIDTH'(1);
            end
        end
    end

    assign fb_swapped   = fb_swapped_r;
    assign display_addr = display_r;
    assign pending      = pend_r;
    assign frames_shown = frames_r;
    assign vsync_idle   = idle_r;
    assign swap_err     = swap_err_r;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fb_swap_ctrl
//
// Bench for fb_swap_ctrl. Two instances are used: u_dut_a is double-buffered
// with 4-bit counters, and u_dut_b is triple-buffered. The stimulus process
// drives directed vectors. For every expected output it queues a record
// (cycle, instance, signal, value), and for every expected scan-out address
// change it queues that address in display order. A monitor on the falling
// edge pops and compares both kinds of expectation.
// -----------------------------------------------------------------------------
module tb_fb_swap_ctrl;

    localparam int AW = 25;

    localparam int SIG_SW    = 0;
    localparam int SIG_ADDR  = 1;
    localparam int SIG_PEND  = 2;
    localparam int SIG_SHOWN = 3;
    localparam int SIG_IDLE  = 4;
    localparam int SIG_ERR   = 5;

    typedef struct {
        int          cyc;
        int          dut;
        int          sig;
        logic [31:0] val;
    } exp_t;

    logic aclk = 1'b0;
    int   cyc  = 0;
    int   checks_n = 0;
    int   fails_n  = 0;

    exp_t            exp_q[$];
    exp_t            keep_q[$];
    logic [AW-1:0]   dq_a[$];
    logic [AW-1:0]   dq_b[$];
    logic [AW-1:0]   last_a = 25'h0;
    logic [AW-1:0]   last_b = 25'h0;
    logic [AW-1:0]   exp_disp;

    // Instance A: double buffering, 4-bit counters
    logic            a_rst, a_swap, a_wv, a_vs;
    logic [AW-1:0]   a_addr;
    logic            a_swapped, a_err;
    logic [AW-1:0]   a_display;
    logic [0:0]      a_pend;
    logic [3:0]      a_shown, a_idle;

    // Instance B: triple buffering, 16-bit counters
    logic            b_rst, b_swap, b_wv, b_vs;
    logic [AW-1:0]   b_addr;
    logic            b_swapped, b_err;
    logic [AW-1:0]   b_display;
    logic [1:0]      b_pend;
    logic [15:0]     b_shown, b_idle;

    fb_swap_ctrl #(.ADDR_WIDTH(AW), .BUFFER_COUNT(2), .FB_RESET_ADDR(25'h0), .CNT_WIDTH(4)) u_dut_a (
        .aclk(aclk), .rst(a_rst), .swap_fb(a_swap), .fb_addr(a_addr),
        .fb_swapped(a_swapped), .wait_vsync(a_wv), .vsync(a_vs),
        .display_addr(a_display), .pending(a_pend), .frames_shown(a_shown),
        .vsync_idle(a_idle), .swap_err(a_err)
    );

    fb_swap_ctrl #(.ADDR_WIDTH(AW), .BUFFER_COUNT(3), .FB_RESET_ADDR(25'h0), .CNT_WIDTH(16)) u_dut_b (
        .aclk(aclk), .rst(b_rst), .swap_fb(b_swap), .fb_addr(b_addr),
        .fb_swapped(b_swapped), .wait_vsync(b_wv), .vsync(b_vs),
        .display_addr(b_display), .pending(b_pend), .frames_shown(b_shown),
        .vsync_idle(b_idle), .swap_err(b_err)
    );

    always #5 aclk = ~aclk;

    // Cycle counter: cycle n lies between the n-th and (n+1)-th rising edge.
    always @(posedge aclk) cyc <= cyc + 1;

    function automatic string sig_name(input int sig);
        case (sig)
            SIG_SW:    return "fb_swapped";
            SIG_ADDR:  return "display_addr";
            SIG_PEND:  return "pending";
            SIG_SHOWN: return "frames_shown";
            SIG_IDLE:  return "vsync_idle";
            SIG_ERR:   return "swap_err";
            default:   return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int dut, input int sig);
        if (dut == 0) begin
            case (sig)
                SIG_SW:    return {31'h0, a_swapped};
                SIG_ADDR:  return {7'h0, a_display};
                SIG_PEND:  return {31'h0, a_pend};
                SIG_SHOWN: return {28'h0, a_shown};
                SIG_IDLE:  return {28'h0, a_idle};
                SIG_ERR:   return {31'h0, a_err};
                default:   return 32'hFFFF_FFFF;
            endcase
        end else begin
            case (sig)
                SIG_SW:    return {31'h0, b_swapped};
                SIG_ADDR:  return {7'h0, b_display};
                SIG_PEND:  return {30'h0, b_pend};
                SIG_SHOWN: return {16'h0, b_shown};
                SIG_IDLE:  return {16'h0, b_idle};
                SIG_ERR:   return {31'h0, b_err};
                default:   return 32'hFFFF_FFFF;
            endcase
        end
    endfunction

    task automatic expect_at(input int dut, input int c, input int sig, input logic [31:0] v);
        exp_t e;
        e.cyc = c; e.dut = dut; e.sig = sig; e.val = v;
        exp_q.push_back(e);
    endtask

    // Advance to cycle n, then move 1 time unit past the rising edge.
    task automatic go(input int n);
        while (cyc < n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    // Monitor: scheduled output checks plus display-address change tracking.
    always @(negedge aclk) begin
        if (cyc >= 1) begin
            keep_q = {};
            foreach (exp_q[i]) begin
                if (exp_q[i].cyc == cyc) begin
                    checks_n++;
                    if (actual(exp_q[i].dut, exp_q[i].sig) !== exp_q[i].val) begin
                        fails_n++;
                        $display("FAIL %s_%s cyc=%0d got=%h exp=%h", (exp_q[i].dut == 0) ? "a" : "b",
                                 sig_name(exp_q[i].sig), cyc, actual(exp_q[i].dut, exp_q[i].sig), exp_q[i].val);
                    end
                end else begin
                    keep_q.push_back(exp_q[i]);
                end
            end
            exp_q = keep_q;

            if (a_display !== last_a) begin
                checks_n++;
                if (dq_a.size() == 0) begin
                    fails_n++;
                    $display("FAIL a_display_change cyc=%0d got=%h exp=no change", cyc, a_display);
                end else begin
                    exp_disp = dq_a.pop_front();
                    if (a_display !== exp_disp) begin
                        fails_n++;
                        $display("FAIL a_display_change cyc=%0d got=%h exp=%h", cyc, a_display, exp_disp);
                    end
                end
                last_a = a_display;
            end

            if (b_display !== last_b) begin
                checks_n++;
                if (dq_b.size() == 0) begin
                    fails_n++;
                    $display("FAIL b_display_change cyc=%0d got=%h exp=no change", cyc, b_display);
                end else begin
                    exp_disp = dq_b.pop_front();
                    if (b_display !== exp_disp) begin
                        fails_n++;
                        $display("FAIL b_display_change cyc=%0d got=%h exp=%h", cyc, b_display, exp_disp);
                    end
                end
                last_b = b_display;
            end
        end
    end

    initial begin
        a_rst = 1'b1; a_swap = 1'b1; a_wv = 1'b0; a_vs = 1'b0; a_addr = 25'h0;
        b_rst = 1'b1; b_swap = 1'b1; b_wv = 1'b0; b_vs = 1'b0; b_addr = 25'h0;

        // ---- Reset with swap_fb held high: no request at release ----
        go(3);
        a_rst = 1'b0; b_rst = 1'b0;
        expect_at(0, 4, SIG_SW, 32'd1);    expect_at(0, 4, SIG_PEND, 32'd0);
        expect_at(0, 4, SIG_ADDR, 32'h0);  expect_at(0, 4, SIG_ERR, 32'd0);
        expect_at(0, 4, SIG_SHOWN, 32'd0); expect_at(0, 4, SIG_IDLE, 32'd0);
        expect_at(1, 4, SIG_SW, 32'd1);    expect_at(1, 4, SIG_PEND, 32'd0);
        expect_at(0, 9, SIG_SW, 32'd1);    expect_at(0, 9, SIG_PEND, 32'd0);
        go(8);
        a_swap = 1'b0; b_swap = 1'b0;

        // ---- A: double buffer, vsync mode, plus protocol error ----
        go(20);
        a_wv = 1'b1; a_addr = 25'h100000; a_swap = 1'b1;
        dq_a.push_back(25'h100000);
        expect_at(0, 21, SIG_SW, 32'd0); expect_at(0, 21, SIG_PEND, 32'd1);
        expect_at(0, 21, SIG_ADDR, 32'h0);
        go(22);
        a_swap = 1'b0; a_addr = 25'h0;
        go(30);
        a_addr = 25'h0ABCDE; a_swap = 1'b1;        // request while not acknowledged
        expect_at(0, 31, SIG_ERR, 32'd1); expect_at(0, 31, SIG_PEND, 32'd1);
        expect_at(0, 31, SIG_SW, 32'd0);
        expect_at(0, 59, SIG_SW, 32'd0); expect_at(0, 59, SIG_ADDR, 32'h0);
        expect_at(0, 59, SIG_PEND, 32'd1);
        go(32);
        a_swap = 1'b0;
        go(60);
        a_vs = 1'b1;
        expect_at(0, 61, SIG_ADDR, 32'h100000); expect_at(0, 61, SIG_SW, 32'd1);
        expect_at(0, 61, SIG_SHOWN, 32'd1);     expect_at(0, 61, SIG_PEND, 32'd0);
        expect_at(0, 61, SIG_ERR, 32'd1);       expect_at(0, 61, SIG_IDLE, 32'd0);
        go(61);
        a_vs = 1'b0;

        // ---- A: 17 idle vsyncs wrap the 4-bit counter to 1 ----
        expect_at(0, 99, SIG_IDLE, 32'd15);
        expect_at(0, 101, SIG_IDLE, 32'd0);
        expect_at(0, 103, SIG_IDLE, 32'd1);
        expect_at(0, 103, SIG_ADDR, 32'h100000);
        expect_at(0, 103, SIG_SHOWN, 32'd1);
        for (int i = 0; i < 17; i++) begin
            go(70 + 2 * i);
            a_vs = 1'b1;
            go(71 + 2 * i);
            a_vs = 1'b0;
        end

        // ---- A: immediate mode ----
        go(110);
        a_wv = 1'b0; a_addr = 25'h300000; a_swap = 1'b1;
        dq_a.push_back(25'h300000);
        expect_at(0, 111, SIG_SW, 32'd0);        expect_at(0, 111, SIG_PEND, 32'd1);
        expect_at(0, 111, SIG_ADDR, 32'h100000);
        expect_at(0, 112, SIG_ADDR, 32'h300000); expect_at(0, 112, SIG_SW, 32'd1);
        expect_at(0, 112, SIG_SHOWN, 32'd2);     expect_at(0, 112, SIG_PEND, 32'd0);
        go(112);
        a_swap = 1'b0;
        go(115);
        a_vs = 1'b1;                               // empty queue, immediate mode
        expect_at(0, 117, SIG_ADDR, 32'h300000); expect_at(0, 117, SIG_IDLE, 32'd1);
        expect_at(0, 117, SIG_SHOWN, 32'd2);
        go(116);
        a_vs = 1'b0;

        // ---- A: reset with a frame still queued ----
        go(120);
        a_wv = 1'b1; a_addr = 25'h400000; a_swap = 1'b1;
        expect_at(0, 121, SIG_PEND, 32'd1); expect_at(0, 121, SIG_SW, 32'd0);
        go(123);
        a_rst = 1'b1;
        dq_a.push_back(25'h0);
        expect_at(0, 124, SIG_PEND, 32'd0);  expect_at(0, 124, SIG_SW, 32'd1);
        expect_at(0, 124, SIG_ADDR, 32'h0);  expect_at(0, 124, SIG_ERR, 32'd0);
        expect_at(0, 124, SIG_SHOWN, 32'd0); expect_at(0, 124, SIG_IDLE, 32'd0);
        expect_at(0, 126, SIG_PEND, 32'd0);  expect_at(0, 126, SIG_SW, 32'd1);
        go(124);
        a_rst = 1'b0;
        go(127);
        a_swap = 1'b0;
        go(130);
        a_vs = 1'b1;
        expect_at(0, 132, SIG_IDLE, 32'd1); expect_at(0, 132, SIG_ADDR, 32'h0);
        expect_at(0, 132, SIG_PEND, 32'd0);
        go(131);
        a_vs = 1'b0;

        // ---- B: triple buffer pipelining ----
        go(150);
        b_wv = 1'b1; b_addr = 25'h100000; b_swap = 1'b1;
        dq_b.push_back(25'h100000);
        expect_at(1, 151, SIG_SW, 32'd0); expect_at(1, 151, SIG_PEND, 32'd1);
        expect_at(1, 152, SIG_SW, 32'd1); expect_at(1, 152, SIG_PEND, 32'd1);
        go(152);
        b_swap = 1'b0;
        go(160);
        b_addr = 25'h200000; b_swap = 1'b1;
        dq_b.push_back(25'h200000);
        expect_at(1, 161, SIG_SW, 32'd0);  expect_at(1, 161, SIG_PEND, 32'd2);
        expect_at(1, 179, SIG_SW, 32'd0);  expect_at(1, 179, SIG_ADDR, 32'h0);
        expect_at(1, 179, SIG_PEND, 32'd2);
        go(162);
        b_swap = 1'b0;
        go(180);
        b_vs = 1'b1;
        expect_at(1, 181, SIG_ADDR, 32'h100000); expect_at(1, 181, SIG_PEND, 32'd1);
        expect_at(1, 181, SIG_SW, 32'd1);        expect_at(1, 181, SIG_SHOWN, 32'd1);
        go(181);
        b_vs = 1'b0;
        go(190);
        b_vs = 1'b1;
        expect_at(1, 191, SIG_ADDR, 32'h200000); expect_at(1, 191, SIG_PEND, 32'd0);
        expect_at(1, 191, SIG_SW, 32'd1);        expect_at(1, 191, SIG_SHOWN, 32'd2);
        go(191);
        b_vs = 1'b0;

        // ---- B: immediate entry after pointer wrap ----
        go(200);
        b_wv = 1'b0; b_addr = 25'h500000; b_swap = 1'b1;
        dq_b.push_back(25'h500000);
        expect_at(1, 201, SIG_SW, 32'd0);        expect_at(1, 201, SIG_PEND, 32'd1);
        expect_at(1, 202, SIG_ADDR, 32'h500000); expect_at(1, 202, SIG_SW, 32'd1);
        expect_at(1, 202, SIG_SHOWN, 32'd3);     expect_at(1, 202, SIG_PEND, 32'd0);
        go(202);
        b_swap = 1'b0;

        // ---- B: push and pop in the same cycle ----
        go(210);
        b_wv = 1'b1; b_addr = 25'h600000; b_swap = 1'b1;
        dq_b.push_back(25'h600000);
        expect_at(1, 211, SIG_PEND, 32'd1); expect_at(1, 211, SIG_SW, 32'd0);
        expect_at(1, 212, SIG_PEND, 32'd1); expect_at(1, 212, SIG_SW, 32'd1);
        go(212);
        b_swap = 1'b0;
        go(220);
        b_addr = 25'h700000; b_swap = 1'b1; b_vs = 1'b1;
        dq_b.push_back(25'h700000);
        expect_at(1, 221, SIG_ADDR, 32'h600000); expect_at(1, 221, SIG_PEND, 32'd1);
        expect_at(1, 221, SIG_SW, 32'd0);        expect_at(1, 221, SIG_SHOWN, 32'd4);
        expect_at(1, 222, SIG_SW, 32'd1);        expect_at(1, 222, SIG_PEND, 32'd1);
        go(221);
        b_vs = 1'b0;
        go(222);
        b_swap = 1'b0;
        go(230);
        b_vs = 1'b1;
        expect_at(1, 231, SIG_ADDR, 32'h700000); expect_at(1, 231, SIG_PEND, 32'd0);
        expect_at(1, 231, SIG_SHOWN, 32'd5);     expect_at(1, 231, SIG_SW, 32'd1);
        expect_at(1, 231, SIG_ERR, 32'd0);       expect_at(1, 231, SIG_IDLE, 32'd0);
        go(231);
        b_vs = 1'b0;

        // ---- Drain: expectations that were never reached count as failures ----
        go(245);
        foreach (exp_q[i]) begin
            checks_n++;
            fails_n++;
            $display("FAIL unreached_%s cyc=%0d got=none exp=%h", sig_name(exp_q[i].sig), exp_q[i].cyc, exp_q[i].val);
        end
        foreach (dq_a[i]) begin
            checks_n++;
            fails_n++;
            $display("FAIL a_display_missing got=none exp=%h", dq_a[i]);
        end
        foreach (dq_b[i]) begin
            checks_n++;
            fails_n++;
            $display("FAIL b_display_missing got=none exp=%h", dq_b[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
        $finish;
    end

endmodule
